// File: rtl/sll_seq.sv
// ----------------------------------------------------------------------------
// sll_seq -- sequential shift-left-logical unit for the 16-bit CPU datapath.
//
// It shifts the captured operand left by one bit per clock. This serves the
// ALU shift path, so the design needs no full barrel shifter. The control
// unit pulses `start` and waits for the one-cycle `done` pulse before it
// writes the result back.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request pulse, accepted only in IDLE or DONE
//   hyrja  in   WIDTH  operand, captured on the accepted start edge
//   shamt  in   SHW    shift amount (0..31), captured on the accepted start
//   dalja  out  WIDTH  result register, valid while done=1, held until the
//                      next accepted start
//   carry  out  1      last bit shifted out of the MSB (0 if no shift)
//   zero   out  1      final result is zero; updated on entry to DONE
//   busy   out  1      high in SHIFT only
//   done   out  1      one-cycle pulse; dalja/carry/zero are valid then
// ----------------------------------------------------------------------------
module sll_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] hyrja,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] dalja,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A shift amount at or below this limit iterates. Anything larger leaves
   // no operand bits behind, so it takes the fast path to DONE.
   localparam logic [SHW-1:0] MAX_ITER = SHW'(WIDTH);
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0] dalja_q, dalja_d;
   logic             carry_q, carry_d;
   logic             zero_q,  zero_d;

   logic [WIDTH-1:0] shifted;
   logic             accept;

   assign shifted = {dalja_q[WIDTH-2:0], 1'b0};

   // A new request is taken only when the unit is not in the middle of a
   // shift. DONE is included so that back-to-back issue is possible.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dalja_d = dalja_q;
      carry_d = carry_q;
      zero_d  = zero_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               carry_d = 1'b0;
               if (shamt == '0) begin
                  dalja_d = hyrja;
                  zero_d  = (hyrja == '0);
                  state_d = DONE;
               end else if (shamt <= MAX_ITER) begin
                  // zero is left as it is here. It is only refreshed when
                  // the shift finishes.
                  dalja_d = hyrja;
                  cnt_d   = shamt;
                  state_d = SHIFT;
               end else begin
                  dalja_d = '0;
                  zero_d  = 1'b1;
                  state_d = DONE;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         SHIFT: begin
            // start, hyrja and shamt are deliberately ignored here.
            dalja_d = shifted;
            carry_d = dalja_q[WIDTH-1];
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               // zero is taken from the value being written on this edge,
               // not from the stale register.
               zero_d  = (shifted == '0);
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dalja_q <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dalja_q <= dalja_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // busy and done decode distinct states. They can never overlap, and busy
   // drops on the same edge that done rises.
   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
   assign dalja = dalja_q;
   assign carry = carry_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_sll_seq.sv
// ----------------------------------------------------------------------------
// tb_sll_seq -- directed self-checking bench for sll_seq.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge.
// ----------------------------------------------------------------------------
module tb_sll_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] hyrja;
   logic [4:0]  shamt;
   logic [15:0] dalja;
   logic        carry;
   logic        zero;
   logic        busy;
   logic        done;

   int vectors;
   int errors;

   sll_seq #(.WIDTH(16), .SHW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .hyrja (hyrja),
      .shamt (shamt),
      .dalja (dalja),
      .carry (carry),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operation, waits for done, and checks the latency and the
   // results. The latency is counted in rising edges after the accept edge
   // E0. When no_wait is set, start is raised immediately, which is used in
   // the DONE cycle. The task returns in the done cycle.
   task automatic do_op(input string name, input logic [15:0] a, input logic [4:0] s,
                        input bit no_wait, input int exp_lat,
                        input logic [15:0] exp_d, input logic exp_c, input logic exp_z);
      int lat;
      if (!no_wait) @(negedge clk);
      start = 1'b1;
      hyrja = a;
      shamt = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      hyrja = 16'hDEAD;
      shamt = 5'd7;
      lat = 0;
      while (!done && lat < 40) begin
         vectors++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_while_wait: got %b want 1 (cycle %0d)", name, busy, lat);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      vectors++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      vectors++;
      if (dalja !== exp_d) begin
         errors++;
         $display("FAIL %s dalja: got %h want %h", name, dalja, exp_d);
      end
      vectors++;
      if (carry !== exp_c) begin
         errors++;
         $display("FAIL %s carry: got %b want %b", name, carry, exp_c);
      end
      vectors++;
      if (zero !== exp_z) begin
         errors++;
         $display("FAIL %s zero: got %b want %b", name, zero, exp_z);
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_with_done: got %b want 0", name, busy);
      end
      $display("op %s: hyrja=%h shamt=%0d -> dalja=%h carry=%b zero=%b lat=%0d",
               name, a, s, dalja, carry, zero, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      hyrja = 16'h0;
      shamt = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({dalja, carry, zero, busy, done} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got dalja=%h c=%b z=%b busy=%b done=%b want all 0",
                  dalja, carry, zero, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
      end
      $display("reset: outputs cleared, idle after release");
   endtask

   task automatic test_basic();
      do_op("sll90x3",   16'd90,    5'd3,  1'b0, 3,  16'd720,   1'b0, 1'b0);
      do_op("sll8001x1", 16'h8001,  5'd1,  1'b0, 1,  16'h0002,  1'b1, 1'b0);
      do_op("sll1234x0", 16'h1234,  5'd0,  1'b0, 0,  16'h1234,  1'b0, 1'b0);
      do_op("sll0001x16",16'h0001,  5'd16, 1'b0, 16, 16'h0000,  1'b1, 1'b1);
      do_op("sllFFFFx20",16'hFFFF,  5'd20, 1'b0, 0,  16'h0000,  1'b0, 1'b1);
   endtask

   // After done, the unit returns to IDLE and holds its results.
   task automatic test_hold();
      do_op("holdpre", 16'h0003, 5'd4, 1'b0, 4, 16'h0030, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({done, busy, dalja, carry, zero} !== {2'b00, 16'h0030, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL hold_idle: got done=%b busy=%b dalja=%h c=%b z=%b want 0 0 0030 0 0",
                  done, busy, dalja, carry, zero);
      end
      $display("hold: dalja=%h held in idle", dalja);
   endtask

   // A second start during SHIFT must be ignored.
   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      start = 1'b1; hyrja = 16'd5; shamt = 5'd8;
      @(posedge clk);            // E0
      #1;
      start = 1'b0;
      @(posedge clk);            // E1
      #1;
      lat = 1;
      @(negedge clk);
      start = 1'b1; hyrja = 16'd7; shamt = 5'd1;
      @(posedge clk);            // E2
      #1;
      lat = 2;
      start = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      vectors++;
      if (lat !== 8) begin
         errors++;
         $display("FAIL ignore_latency: got %0d want 8", lat);
      end
      vectors++;
      if (dalja !== 16'd1280) begin
         errors++;
         $display("FAIL ignore_dalja: got %0d want 1280", dalja);
      end
      $display("ignore: dalja=%0d lat=%0d", dalja, lat);
   endtask

   // Reset asserted mid-shift aborts the operation immediately.
   task automatic test_reset_abort();
      @(negedge clk);
      start = 1'b1; hyrja = 16'd5; shamt = 5'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({dalja, carry, zero, busy, done} !== 20'h0) begin
         errors++;
         $display("FAIL abort_outputs: got dalja=%h c=%b z=%b busy=%b done=%b want all 0",
                  dalja, carry, zero, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
      end
      $display("abort: reset mid-shift cleared outputs");
      do_op("after_abort", 16'd3, 5'd2, 1'b0, 2, 16'd12, 1'b0, 1'b0);
   endtask

   // A start raised in the DONE cycle is accepted on the next edge.
   task automatic test_back_to_back();
      do_op("b2b_first",  16'h00F0, 5'd4, 1'b0, 4, 16'h0F00, 1'b0, 1'b0);
      do_op("b2b_second", 16'hC000, 5'd2, 1'b1, 2, 16'h0000, 1'b1, 1'b1);
      do_op("b2b_third",  16'h0ABC, 5'd0, 1'b1, 0, 16'h0ABC, 1'b0, 1'b0);
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_basic();
      test_hold();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/sll_seq.md
Name: sll_seq

Overview:
- Sequential shift-left-logical unit for the 16-bit CPU datapath. It is the left-shifting counterpart of the combinational SRA block.
- It shifts one bit per clock under a start/done handshake, so the control FSM can issue SLL without a full barrel shifter.
- It sits in the ALU shift path; the control unit pulses `start` and waits for `done` before writeback.
- It also exports the last bit shifted out and a zero flag.

Parameters:
- WIDTH, 16, datapath width; fixed at 16 for this CPU. Behaviour below assumes 16.
- SHW, 5, shift-amount width; shamt range 0..31.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- hyrja  input  16  operand, captured on the accepted start edge.
- shamt  input  5  shift amount, captured on the accepted start edge.
- dalja  output  16  result register; valid while done=1 and held until the next accepted start.
- carry  output  1  last bit shifted out of bit 15; 0 if no shift occurred.
- zero  output  1  1 when the final result is 0x0000; updated on entry to DONE.
- busy  output  1  1 in SHIFT state only.
- done  output  1  one-cycle pulse; result, carry and zero are valid in this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - dalja=16'h0000, carry=0, zero=0, busy=0, done=0, cnt=0.
  - Reset asserted mid-operation aborts the shift; after release the unit sits in IDLE and waits for a new start.
- States: IDLE, SHIFT, DONE. cnt is 5 bits.
- Accepted start (state is IDLE or DONE, start=1) at edge E0:
  - shamt=0: dalja<=hyrja, carry<=0, zero<=(hyrja==0), state<=DONE.
  - shamt 1..16: dalja<=hyrja, cnt<=shamt, carry<=0, state<=SHIFT.
  - shamt 17..31: dalja<=0, carry<=0, zero<=1, state<=DONE. This is the fast path with no iteration.
- SHIFT, each edge:
  - dalja<={dalja[14:0],1'b0}, carry<=dalja[15], cnt<=cnt-1.
  - When cnt==1: state<=DONE, and zero<=(next dalja==0), computed from the shifted value.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: state<=IDLE, unless start=1, which is accepted as above (back-to-back operation).
- Latency: done is high in the cycle after edge E_k, where k=shamt for shamt 1..16 and k=0 for shamt 0 or 17..31.
- start while in SHIFT is ignored; hyrja and shamt changes during SHIFT have no effect.
- dalja, carry and zero hold their values through IDLE until the next accepted start. Intermediate values of dalja are visible during SHIFT and are not valid results.
- shamt=16: every input bit is shifted out. Result 0, carry=hyrja[0], zero=1.
- busy and done are never high together. busy falls on the same edge that done rises.

Test Plan:
- hyrja=90, shamt=3 → busy for 3 cycles; done in the cycle after E3; dalja=720, carry=0, zero=0.
- hyrja=16'h8001, shamt=1 → done after E1; dalja=16'h0002, carry=1, zero=0.
- hyrja=16'h1234, shamt=0 → done after E0, busy never high; dalja=16'h1234, carry=0.
- hyrja=16'h0001, shamt=16 → done after E16; dalja=0, carry=1, zero=1.
- hyrja=16'hFFFF, shamt=20 → done after E0; dalja=0, carry=0, zero=1.
- Start hyrja=5, shamt=8; at E2 pulse start with hyrja=7, shamt=1 → second start ignored, final dalja=1280.
- Second run: repeat the shamt=8 operation, drop rst_n during SHIFT → outputs 0 immediately. After release, start 3, shamt 2 → dalja=12.
- Back-to-back: start asserted in the DONE cycle is accepted, and the new result arrives with correct latency.
